// File: rtl/tone_pkg.sv
// Shared types and tables for the tone sequencer: note dividers, state encoding, song ROM.
package tone_pkg;

  localparam logic [3:0] REST      = 4'hF;
  localparam logic [3:0] LAST_NOTE = 4'd9;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    LOAD   = 2'd1,
    PLAY   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // NOTE_DIV table; out-of-range indices fall back to the reset note.
  function automatic logic [12:0] note_div(input logic [3:0] idx);
    case (idx)
      4'd0:    note_div = 13'h1388;
      4'd1:    note_div = 13'h0904;
      4'd2:    note_div = 13'h0683;
      4'd3:    note_div = 13'h04e2;
      4'd4:    note_div = 13'h03e8;
      4'd5:    note_div = 13'h0341;
      4'd6:    note_div = 13'h02ca;
      4'd7:    note_div = 13'h0271;
      4'd8:    note_div = 13'h022c;
      4'd9:    note_div = 13'h01f4;
      default: note_div = 13'h1388;
    endcase
  endfunction

  // Each entry is {note[3:0], dur[3:0]}.
  function automatic logic [7:0] song_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    song_rom = 8'h01;
      4'd1:    song_rom = 8'hF0;
      4'd2:    song_rom = 8'h92;
      4'd3:    song_rom = 8'h23;
      4'd4:    song_rom = 8'h45;
      4'd5:    song_rom = 8'h60;
      4'd6:    song_rom = 8'h71;
      4'd7:    song_rom = 8'h82;
      4'd8:    song_rom = 8'h93;
      4'd9:    song_rom = 8'hF1;
      4'd10:   song_rom = 8'h52;
      4'd11:   song_rom = 8'h33;
      4'd12:   song_rom = 8'h14;
      4'd13:   song_rom = 8'h05;
      4'd14:   song_rom = 8'hA0;
      default: song_rom = 8'h03;
    endcase
  endfunction

endpackage

// File: rtl/tone_sequencer_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks, restartable via clear.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == TERM);

  // Wrap on the tick so back-to-back intervals stay exactly TICK_DIV long.
  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Tone controller: manual note stepping, or timed playback of the song ROM with gaps between steps.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int DUR_UNIT  = 50,
  parameter int GAP_TICKS = 20,
  parameter int SONG_LEN  = 16
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        key_next,
  input  logic        key_play,
  output logic [12:0] div,
  output logic        tone_en,
  output logic [3:0]  note_idx,
  output logic [3:0]  step,
  output logic        busy,
  output logic        done
);

  state_t      state_q;
  logic [3:0]  noteIdx_q;
  logic [12:0] div_q;
  logic        toneEn_q;
  logic [3:0]  step_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] durCnt_q;
  logic [15:0] gapCnt_q;
  logic        nextHist_q;
  logic        playHist_q;

  logic        tick;
  logic        nextPress;
  logic        playPress;
  logic [3:0]  nextNote;
  logic [7:0]  romWord;
  logic [3:0]  romNote;
  logic        romRest;
  logic [15:0] durLoad;
  logic        lastStep;

  assign nextPress = nextHist_q & ~key_next;
  assign playPress = playHist_q & ~key_play;
  assign nextNote  = (noteIdx_q == LAST_NOTE) ? 4'd0 : noteIdx_q + 4'd1;

  assign romWord  = song_rom(step_q);
  assign romNote  = romWord[7:4];
  assign romRest  = (romNote > LAST_NOTE);
  assign durLoad  = 16'((32'(romWord[3:0]) + 32'd1) * 32'(DUR_UNIT));
  assign lastStep = (step_q == 4'(SONG_LEN - 1));

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .arst_i  (arst),
    .clear_i (state_q == LOAD),
    .tick_o  (tick)
  );

  // div is always reloaded together with note_idx so the two never disagree.
  always_ff @(posedge clk) begin
    if (!arst) begin
      state_q    <= MANUAL;
      noteIdx_q  <= 4'd0;
      div_q      <= 13'h1388;
      toneEn_q   <= 1'b1;
      step_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      durCnt_q   <= 16'd0;
      gapCnt_q   <= 16'd0;
      nextHist_q <= 1'b1;
      playHist_q <= 1'b1;
    end else begin
      nextHist_q <= key_next;
      playHist_q <= key_play;
      done_q     <= 1'b0;
      case (state_q)
        MANUAL: begin
          toneEn_q <= 1'b1;
          step_q   <= 4'd0;
          busy_q   <= 1'b0;
          if (playPress) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end else if (nextPress) begin
            noteIdx_q <= nextNote;
            div_q     <= note_div(nextNote);
          end
        end
        LOAD: begin
          if (playPress) begin
            state_q  <= MANUAL;
            busy_q   <= 1'b0;
            step_q   <= 4'd0;
            toneEn_q <= 1'b1;
          end else begin
            if (romRest) begin
              toneEn_q <= 1'b0;
            end else begin
              noteIdx_q <= romNote;
              div_q     <= note_div(romNote);
              toneEn_q  <= 1'b1;
            end
            durCnt_q <= durLoad;
            state_q  <= PLAY;
          end
        end
        PLAY: begin
          if (playPress) begin
            state_q  <= MANUAL;
            busy_q   <= 1'b0;
            step_q   <= 4'd0;
            toneEn_q <= 1'b1;
          end else if (tick) begin
            durCnt_q <= durCnt_q - 16'd1;
            if (durCnt_q == 16'd1) begin
              toneEn_q <= 1'b0;
              gapCnt_q <= 16'(GAP_TICKS);
              state_q  <= GAP;
            end
          end
        end
        GAP: begin
          toneEn_q <= 1'b0;
          if (playPress) begin
            state_q  <= MANUAL;
            busy_q   <= 1'b0;
            step_q   <= 4'd0;
            toneEn_q <= 1'b1;
          end else if (tick) begin
            gapCnt_q <= gapCnt_q - 16'd1;
            if (gapCnt_q == 16'd1) begin
              if (lastStep) begin
                done_q   <= 1'b1;
                state_q  <= MANUAL;
                busy_q   <= 1'b0;
                step_q   <= 4'd0;
                toneEn_q <= 1'b1;
              end else begin
                step_q  <= step_q + 4'd1;
                state_q <= LOAD;
              end
            end
          end
        end
        default: begin
          state_q  <= MANUAL;
          busy_q   <= 1'b0;
          step_q   <= 4'd0;
          toneEn_q <= 1'b1;
        end
      endcase
    end
  end

  assign div      = div_q;
  assign tone_en  = toneEn_q;
  assign note_idx = noteIdx_q;
  assign step     = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer with a shortened timebase and 3-step song.
module tb_tone_sequencer;

  logic        clk;
  logic        arst;
  logic        key_next;
  logic        key_play;
  logic [12:0] div;
  logic        tone_en;
  logic [3:0]  note_idx;
  logic [3:0]  step;
  logic        busy;
  logic        done;

  int testsRun;
  int testsFailed;

  logic [12:0] expDiv [10] = '{13'h1388, 13'h0904, 13'h0683, 13'h04e2, 13'h03e8,
                               13'h0341, 13'h02ca, 13'h0271, 13'h022c, 13'h01f4};

  tone_sequencer #(
    .TICK_DIV  (4),
    .DUR_UNIT  (2),
    .GAP_TICKS (1),
    .SONG_LEN  (3)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .key_next (key_next),
    .key_play (key_play),
    .div      (div),
    .tone_en  (tone_en),
    .note_idx (note_idx),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  // 10 ns clock; all driving and sampling happens 1 ns after the rising edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pressNext();
    key_next = 1'b0;
    waitCycle();
    key_next = 1'b1;
    waitCycle();
  endtask

  // Leaves the bench one sample after the LOAD cycle (first PLAY cycle)
  task automatic pressPlay();
    key_play = 1'b0;
    waitCycle();
    key_play = 1'b1;
    waitCycle();
  endtask

  // Counts consecutive samples with tone_en == val, bounded
  task automatic countRun(input logic val, output int n);
    n = 0;
    while (tone_en === val && n < 400) begin
      n++;
      waitCycle();
    end
  endtask

  task automatic test_reset();
    arst = 1'b0;
    key_next = 1'b0;
    key_play = 1'b0;
    repeat (3) waitCycle();
    testsRun++;
    if (div !== 13'h1388 || note_idx !== 4'd0 || tone_en !== 1'b1 || step !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: div=%h note=%0d tone_en=%b step=%0d busy=%b done=%b, want 1388/0/1/0/0/0",
               div, note_idx, tone_en, step, busy, done);
    end
    key_next = 1'b1;
    key_play = 1'b1;
    waitCycle();
    arst = 1'b1;
    repeat (4) waitCycle();
    testsRun++;
    if (div !== 13'h1388 || note_idx !== 4'd0 || tone_en !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL after_reset_no_press: div=%h note=%0d tone_en=%b busy=%b, want 1388/0/1/0",
               div, note_idx, tone_en, busy);
    end
  endtask

  task automatic test_manual_next();
    for (int i = 0; i < 11; i++) begin
      pressNext();
      testsRun++;
      if (note_idx !== 4'((i + 1) % 10) || div !== expDiv[(i + 1) % 10]) begin
        testsFailed++;
        $display("[TB] FAIL next_press_%0d: note=%0d div=%h, want %0d/%h",
                 i, note_idx, div, (i + 1) % 10, expDiv[(i + 1) % 10]);
      end
    end
    testsRun++;
    if (div !== 13'h0904 || step !== 4'd0 || busy !== 1'b0 || tone_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL manual_end: div=%h step=%0d busy=%b tone_en=%b, want 0904/0/0/1",
               div, step, busy, tone_en);
    end
  endtask

  task automatic test_song();
    int n;
    key_play = 1'b0;
    waitCycle();
    testsRun++;
    if (busy !== 1'b1 || note_idx !== 4'd1 || step !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL load_entry: busy=%b note=%0d step=%0d, want 1/1/0", busy, note_idx, step);
    end
    key_play = 1'b1;
    waitCycle();
    testsRun++;
    if (note_idx !== 4'd0 || div !== 13'h1388 || tone_en !== 1'b1 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL step0_start: note=%0d div=%h tone_en=%b busy=%b, want 0/1388/1/1",
               note_idx, div, tone_en, busy);
    end
    countRun(1'b1, n);
    testsRun++;
    if (n !== 16) begin
      testsFailed++;
      $display("[TB] FAIL step0_tone_len: got %0d cycles, want 16", n);
    end
    // gap0 (4) + LOAD (1) + rest play (8) + gap1 (4) + LOAD (1)
    countRun(1'b0, n);
    testsRun++;
    if (n !== 18) begin
      testsFailed++;
      $display("[TB] FAIL silent_len: got %0d cycles, want 18", n);
    end
    testsRun++;
    if (note_idx !== 4'd9 || div !== 13'h01f4 || step !== 4'd2 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL step2_start: note=%0d div=%h step=%0d busy=%b, want 9/01f4/2/1",
               note_idx, div, step, busy);
    end
    countRun(1'b1, n);
    testsRun++;
    if (n !== 24) begin
      testsFailed++;
      $display("[TB] FAIL step2_tone_len: got %0d cycles, want 24", n);
    end
    countRun(1'b0, n);
    testsRun++;
    if (n !== 4) begin
      testsFailed++;
      $display("[TB] FAIL final_gap_len: got %0d cycles, want 4", n);
    end
    testsRun++;
    if (done !== 1'b1 || busy !== 1'b0 || note_idx !== 4'd9 || tone_en !== 1'b1 || step !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL song_done: done=%b busy=%b note=%0d tone_en=%b step=%0d, want 1/0/9/1/0",
               done, busy, note_idx, tone_en, step);
    end
    waitCycle();
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL done_one_cycle: done=%b, want 0", done);
    end
  endtask

  task automatic test_abort();
    int n;
    int doneSeen;
    pressPlay();
    n = 0;
    while (step !== 4'd1 && n < 200) begin
      n++;
      waitCycle();
    end
    repeat (3) waitCycle();
    testsRun++;
    if (step !== 4'd1 || tone_en !== 1'b0 || note_idx !== 4'd0 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rest_play: step=%0d tone_en=%b note=%0d busy=%b, want 1/0/0/1",
               step, tone_en, note_idx, busy);
    end
    key_play = 1'b0;
    waitCycle();
    key_play = 1'b1;
    testsRun++;
    if (busy !== 1'b0 || tone_en !== 1'b1 || step !== 4'd0 || note_idx !== 4'd0 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort: busy=%b tone_en=%b step=%0d note=%0d done=%b, want 0/1/0/0/0",
               busy, tone_en, step, note_idx, done);
    end
    doneSeen = 0;
    for (int i = 0; i < 60; i++) begin
      waitCycle();
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    testsRun++;
    if (doneSeen !== 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_quiet: %0d cycles with done/busy high, want 0", doneSeen);
    end
  endtask

  task automatic test_both_keys();
    pressNext();
    key_next = 1'b0;
    key_play = 1'b0;
    waitCycle();
    key_next = 1'b1;
    key_play = 1'b1;
    testsRun++;
    if (busy !== 1'b1 || note_idx !== 4'd1 || div !== 13'h0904) begin
      testsFailed++;
      $display("[TB] FAIL both_keys: busy=%b note=%0d div=%h, want 1/1/0904", busy, note_idx, div);
    end
    repeat (3) waitCycle();
    pressNext();
    testsRun++;
    if (note_idx !== 4'd0 || busy !== 1'b1 || step !== 4'd0 || tone_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL next_in_play: note=%0d busy=%b step=%0d tone_en=%b, want 0/1/0/1",
               note_idx, busy, step, tone_en);
    end
  endtask

  task automatic test_reset_mid_gap();
    int n;
    int doneSeen;
    n = 0;
    while (tone_en !== 1'b0 && n < 200) begin
      n++;
      waitCycle();
    end
    waitCycle();
    arst = 1'b0;
    waitCycle();
    arst = 1'b1;
    testsRun++;
    if (div !== 13'h1388 || note_idx !== 4'd0 || tone_en !== 1'b1 || step !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_gap: div=%h note=%0d tone_en=%b step=%0d busy=%b done=%b, want 1388/0/1/0/0/0",
               div, note_idx, tone_en, step, busy, done);
    end
    doneSeen = 0;
    for (int i = 0; i < 60; i++) begin
      waitCycle();
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    testsRun++;
    if (doneSeen !== 0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_quiet: %0d cycles with done/busy high, want 0", doneSeen);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    arst = 1'b0;
    key_next = 1'b1;
    key_play = 1'b1;
    #1;
    test_reset();
    test_manual_next();
    test_song();
    test_abort();
    test_both_keys();
    test_reset_mid_gap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
